// File: rtl/regfile_arbiter_2x_if.sv
// Requester-side bus of the two-port register file arbiter.
// master = requester side, slave = arbiter side.
interface regfile_arbiter_2x_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 3
);
  logic [1:0]    Req;
  logic [1:0]    Wr;
  logic [AW-1:0] Addr0;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] WData0;
  logic [DW-1:0] WData1;
  logic [1:0]    Gnt;
  logic [1:0]    RValid;
  logic [DW-1:0] RData;

  modport master (
    output Req, Wr, Addr0, Addr1, WData0, WData1,
    input  Gnt, RValid, RData
  );

  modport slave (
    input  Req, Wr, Addr0, Addr1, WData0, WData1,
    output Gnt, RValid, RData
  );
endinterface

// File: rtl/regfile_arbiter_2x.sv
// Round-robin sharing of an 8x32 register file's read/write ports between two
// requesters, plus a hardware sequence that writes zero to every register.
module regfile_arbiter_2x #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  regfile_arbiter_2x_if.slave  bus,
  input  logic                 Clr_Req,
  output logic                 Clr_Busy,
  output logic                 Clr_Done,
  output logic [AW-1:0]        RF_RAddr,
  output logic [AW-1:0]        RF_WAddr,
  output logic                 RF_WEn,
  output logic [DW-1:0]        RF_WData,
  input  logic [DW-1:0]        RF_RData
);

  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state;
  logic          ptr;
  logic [AW-1:0] cnt;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          clr_done_q;

  logic [1:0]    gnt;
  logic [1:0]    gnt_rd;
  logic          gnt_wr;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  // Grant selection; held off during reset so nothing reaches the file.
  always_comb begin
    gnt = 2'b00;
    if (!Rst && state == SERVE) begin
      case (bus.Req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_wr    = |(gnt & bus.Wr);
  assign gnt_rd    = gnt & ~bus.Wr;
  assign gnt_addr  = gnt[1] ? bus.Addr1  : bus.Addr0;
  assign gnt_wdata = gnt[1] ? bus.WData1 : bus.WData0;

  // Register-file pins: clear sweep owns the write port while clearing.
  always_comb begin
    RF_WEn   = 1'b0;
    RF_WAddr = '0;
    RF_WData = '0;
    RF_RAddr = '0;
    if (!Rst) begin
      if (state == CLEAR) begin
        RF_WEn   = 1'b1;
        RF_WAddr = cnt;
      end else if (gnt_wr) begin
        RF_WEn   = 1'b1;
        RF_WAddr = gnt_addr;
        RF_WData = gnt_wdata;
      end else if (|gnt) begin
        RF_RAddr = gnt_addr;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= SERVE;
      ptr        <= 1'b0;
      cnt        <= '0;
      rvalid_q   <= 2'b00;
      rdata_q    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      rvalid_q   <= gnt_rd;
      if (|gnt_rd) begin
        rdata_q <= RF_RData;
      end
      // Only a contested grant hands priority to the other requester.
      if (bus.Req == 2'b11 && |gnt) begin
        ptr <= ~ptr;
      end
      case (state)
        SERVE: begin
          if (Clr_Req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (&cnt) begin
            state      <= SERVE;
            clr_done_q <= 1'b1;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  assign bus.Gnt    = gnt;
  assign bus.RValid = rvalid_q;
  assign bus.RData  = rdata_q;
  assign Clr_Busy   = (state == CLEAR);
  assign Clr_Done   = clr_done_q;

endmodule

// File: tb/tb_regfile_arbiter_2x.sv
// Directed bench for regfile_arbiter_2x with a behavioural 8x32 register file
// that resets to zero on Rst.
module tb_regfile_arbiter_2x;

  logic        Clk;
  logic        Rst;
  logic        Clr_Req;
  logic        Clr_Busy;
  logic        Clr_Done;
  logic [2:0]  RF_RAddr;
  logic [2:0]  RF_WAddr;
  logic        RF_WEn;
  logic [31:0] RF_WData;
  logic [31:0] RF_RData;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf [8];

  regfile_arbiter_2x_if #(.DW(32), .AW(3)) bus ();

  regfile_arbiter_2x #(.DW(32), .AW(3)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus.slave),
    .Clr_Req  (Clr_Req),
    .Clr_Busy (Clr_Busy),
    .Clr_Done (Clr_Done),
    .RF_RAddr (RF_RAddr),
    .RF_WAddr (RF_WAddr),
    .RF_WEn   (RF_WEn),
    .RF_WData (RF_WData),
    .RF_RData (RF_RData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file: synchronous write, combinational read, cleared by reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'd0;
    end else if (RF_WEn) begin
      rf[RF_WAddr] <= RF_WData;
    end
  end
  assign RF_RData = rf[RF_RAddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] wr,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.Req    = req;
    bus.Wr     = wr;
    bus.Addr0  = a0;
    bus.Addr1  = a1;
    bus.WData0 = d0;
    bus.WData1 = d1;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    drive(2'b01, 2'b01, a, 3'd0, d, 32'd0);
    cyc();
  endtask

  initial begin
    Rst     = 1'b1;
    Clr_Req = 1'b0;
    drive(2'b11, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);

    // Reset held with both requesting
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("rst_gnt", 32'(bus.Gnt), 32'd0);
      chk("rst_rvalid", 32'(bus.RValid), 32'd0);
      chk("rst_rdata", bus.RData, 32'd0);
      chk("rst_wen", 32'(RF_WEn), 32'd0);
      chk("rst_busy", 32'(Clr_Busy), 32'd0);
    end
    Rst = 1'b0;
    #1 chk("post_rst_m0", 32'(bus.Gnt), 32'd1);
    cyc(); #1;
    chk("post_rst_m1", 32'(bus.Gnt), 32'd2);
    chk("post_rst_rv0", 32'(bus.RValid), 32'd1);
    cyc();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
    #1 chk("post_rst_rv1", 32'(bus.RValid), 32'd2);

    // Write then read the same address
    drive(2'b01, 2'b01, 3'd5, 3'd0, 32'hDEADBEEF, 32'd0);
    #1;
    chk("wr_gnt", 32'(bus.Gnt), 32'd1);
    chk("wr_wen", 32'(RF_WEn), 32'd1);
    chk("wr_waddr", 32'(RF_WAddr), 32'd5);
    chk("wr_wdata", RF_WData, 32'hDEADBEEF);
    cyc();
    drive(2'b10, 2'b00, 3'd0, 3'd5, 32'd0, 32'd0);
    #1;
    chk("rd_gnt", 32'(bus.Gnt), 32'd2);
    chk("rd_no_rv_after_wr", 32'(bus.RValid), 32'd0);
    chk("rd_wen_low", 32'(RF_WEn), 32'd0);
    cyc();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("rd_rvalid", 32'(bus.RValid), 32'd2);
    chk("rd_rdata", bus.RData, 32'hDEADBEEF);

    // Contention, preceded by uncontested preload
    wr0(3'd1, 32'h11);
    wr0(3'd2, 32'h22);
    drive(2'b11, 2'b00, 3'd1, 3'd2, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_gnt", 32'(bus.Gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) begin
        chk("cont_rv", 32'(bus.RValid), (i % 2 == 0) ? 32'd2 : 32'd1);
        chk("cont_rd", bus.RData, (i % 2 == 0) ? 32'h22 : 32'h11);
      end
      cyc();
    end
    drive(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("cont_rv_last", 32'(bus.RValid), 32'd2);
    chk("cont_rd_last", bus.RData, 32'h22);
    cyc();
    #1 chk("idle_rv", 32'(bus.RValid), 32'd0);
    chk("idle_rd_hold", bus.RData, 32'h22);

    // Uncontested streak leaves the pointer on M0
    drive(2'b01, 2'b00, 3'd1, 3'd2, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("streak_gnt", 32'(bus.Gnt), 32'd1);
      cyc();
    end
    drive(2'b11, 2'b00, 3'd1, 3'd2, 32'd0, 32'd0);
    #1 chk("streak_still_m0", 32'(bus.Gnt), 32'd1);
    cyc();
    #1 chk("streak_then_m1", 32'(bus.Gnt), 32'd2);
    cyc();

    // Hardware clear
    for (int i = 0; i < 8; i++) wr0(3'(i), 32'hFFFFFFFF);
    drive(2'b01, 2'b00, 3'd4, 3'd0, 32'd0, 32'd0);
    Clr_Req = 1'b1;
    #1 chk("clr_req_gnt", 32'(bus.Gnt), 32'd1);
    cyc();
    Clr_Req = 1'b0;
    drive(2'b10, 2'b00, 3'd0, 3'd6, 32'd0, 32'd0);
    #1;
    chk("clr_pending_rv", 32'(bus.RValid), 32'd1);
    chk("clr_pending_rd", bus.RData, 32'hFFFFFFFF);
    for (int k = 0; k < 8; k++) begin
      Clr_Req = (k == 2);
      #1;
      chk("clr_busy", 32'(Clr_Busy), 32'd1);
      chk("clr_gnt", 32'(bus.Gnt), 32'd0);
      chk("clr_wen", 32'(RF_WEn), 32'd1);
      chk("clr_waddr", 32'(RF_WAddr), 32'(k));
      chk("clr_wdata", RF_WData, 32'd0);
      chk("clr_done_early", 32'(Clr_Done), 32'd0);
      cyc();
    end
    Clr_Req = 1'b0;
    #1;
    chk("clr_busy_end", 32'(Clr_Busy), 32'd0);
    chk("clr_done", 32'(Clr_Done), 32'd1);
    chk("clr_resume_m1", 32'(bus.Gnt), 32'd2);
    cyc();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("clr_done_pulse", 32'(Clr_Done), 32'd0);
    chk("clr_busy_stays", 32'(Clr_Busy), 32'd0);
    chk("clr_m1_rv", 32'(bus.RValid), 32'd2);
    chk("clr_m1_rd", bus.RData, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 2'b00, 3'(i), 3'd0, 32'd0, 32'd0);
      cyc();
      #1;
      chk("clr_readback_rv", 32'(bus.RValid), 32'd1);
      chk("clr_readback", bus.RData, 32'd0);
    end

    // Reset in the middle of a clear
    for (int i = 0; i < 8; i++) wr0(3'(i), 32'hFFFFFFFF);
    drive(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
    Clr_Req = 1'b1;
    cyc();
    Clr_Req = 1'b0;
    cyc(); cyc(); cyc();
    #1;
    chk("mid_waddr", 32'(RF_WAddr), 32'd3);
    chk("mid_rf0", rf[0], 32'd0);
    chk("mid_rf2", rf[2], 32'd0);
    chk("mid_rf3", rf[3], 32'hFFFFFFFF);
    Rst = 1'b1;
    #1 chk("mid_wen_gated", 32'(RF_WEn), 32'd0);
    cyc();
    Rst = 1'b0;
    #1;
    chk("mid_busy", 32'(Clr_Busy), 32'd0);
    chk("mid_no_done", 32'(Clr_Done), 32'd0);
    drive(2'b01, 2'b00, 3'd7, 3'd0, 32'd0, 32'd0);
    #1 chk("mid_serve_gnt", 32'(bus.Gnt), 32'd1);
    cyc();
    #1;
    chk("mid_no_done2", 32'(Clr_Done), 32'd0);
    chk("mid_rd7", bus.RData, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter_2x.md
Name: regfile_arbiter_2x

Overview:
- Shares the single read port and single write port of the 8x32 register file between two requesters, M0 and M1.
- Arbitration is round-robin, one access per cycle. Read data is returned registered, one cycle after the grant.
- Also runs a hardware clear sequence that writes zero to all 8 registers without a global reset.
- Sits between the requesters (core datapath, debug/loader unit) and the register file's R_Addr/W_Addr/W_En/W_Data/R_Data pins.

Parameters:
- DW, 32, data width; must match the register file width.
- AW, 3, address width; the register file depth is 2**AW = 8.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  2  per-requester request; bit i = Mi.
- Wr  in  2  per-requester op; 1 = write, 0 = read.
- Addr0  in  AW  M0 register address.
- Addr1  in  AW  M1 register address.
- WData0  in  DW  M0 write data.
- WData1  in  DW  M1 write data.
- Gnt  out  2  one-hot or zero; the request is accepted in the cycle Gnt[i]=1.
- RValid  out  2  one-hot or zero; read data for Mi is valid on RData.
- RData  out  DW  registered read data.
- Clr_Req  in  1  single-cycle pulse; starts the clear sequence.
- Clr_Busy  out  1  high while clearing.
- Clr_Done  out  1  one-cycle pulse when the clear completes.
- RF_RAddr  out  AW  to register file R_Addr.
- RF_WAddr  out  AW  to register file W_Addr.
- RF_WEn  out  1  to register file W_En.
- RF_WData  out  DW  to register file W_Data.
- RF_RData  in  DW  from register file R_Data (combinational read).

Behaviour:
- Reset (Rst=1 at a clock edge):
  - state=SERVE, priority pointer=M0, clear counter=0.
  - Gnt=0, RValid=0, RData=0, Clr_Busy=0, Clr_Done=0.
  - RF_WEn=0, RF_RAddr=0, RF_WAddr=0, RF_WData=0.
  - Reset mid-clear aborts the clear, and no Clr_Done is issued.
- Gnt, RF_WEn and the RF_* addresses/data are combinational from state, Req, Wr, Addr and the pointer.
  - RF_WEn is additionally gated by Rst=0.
  - RData, RValid, Clr_Done and the pointer are registered.
- State SERVE:
  - Only Req[0] set: Gnt=01. Only Req[1] set: Gnt=10.
  - Both set: grant goes to the pointer's requester.
  - The pointer toggles to the other requester only after a contested grant. Uncontested grants leave it unchanged.
  - Granted write: RF_WAddr=Addr, RF_WData=WData, RF_WEn=1. The write commits at the edge ending the grant cycle.
  - Granted read: RF_RAddr=Addr. At the edge, RData <= RF_RData and RValid[i] <= 1 for exactly one cycle. Read latency is 1 cycle from the grant.
  - No grant: RF_WEn=0, RValid <= 0, RData holds its last value.
  - Read and write to the same address in different cycles: the read granted the cycle after a write returns the new value.
  - Requesters must hold Req/Wr/Addr/WData stable until granted. A dropped request before grant is simply not served.
  - Both requesters may be granted back-to-back every cycle. No bubbles.
- Clr_Req sampled high in SERVE:
  - Go to CLEAR at the next edge.
  - A grant in that same cycle still completes, and its RValid still occurs.
- State CLEAR:
  - Gnt=0. Requests are stalled, not dropped.
  - Clr_Busy=1, RF_WEn=1, RF_WAddr=counter, RF_WData=0.
  - The counter runs 0..7, one address per cycle, for 8 cycles total.
  - On the counter=7 cycle the counter wraps to 0, the state returns to SERVE, and Clr_Done=1 in the first SERVE cycle.
  - Clr_Req while in CLEAR is ignored.
  - Grants resume in the first SERVE cycle; the pointer is unchanged by the clear.
- Invariants:
  - Gnt never has both bits set.
  - RF_WEn is never high with Gnt=0 except in CLEAR.
  - An RValid bit is set only for a read grant in the previous cycle.

Test Plan:
1. Reset: Rst=1 for 2 cycles with Req=11 -> Gnt=00, RValid=00, RData=0, RF_WEn=0 throughout; first post-reset contested cycle grants M0.
2. Write then read: M0 writes 0xDEADBEEF to addr 5, then the next cycle M1 reads addr 5 -> Gnt=01 then 10; RValid=10 and RData=0xDEADBEEF in the cycle after the read grant.
3. Contention: Req=11 held for 6 cycles, all reads (M0 addr 1, M1 addr 2, pre-loaded 0x11, 0x22) -> Gnt alternates 01,10,01,10,01,10; RData alternates 0x11/0x22, each one cycle behind its grant.
4. Uncontested streak: Req=01 for 3 cycles, then Req=11 -> M0 granted 3 times, then still M0, since the pointer was not advanced by uncontested grants; then M1.
5. Clear: pre-load all 8 registers with 0xFFFFFFFF, pulse Clr_Req with M1 requesting -> Clr_Busy high for exactly 8 cycles, RF_WAddr 0..7, Gnt=00; Clr_Done one pulse; M1 is granted in the same cycle as Clr_Done; reads of addr 0..7 then return 0.
6. Reset mid-clear: Rst asserted at counter=3 -> Clr_Busy=0 next cycle, no Clr_Done, state SERVE; registers 0..2 were zeroed and the remaining registers are cleared by the register-file reset itself.
